// File: rtl/f1_sweep_checker.sv
// Sweeps {a,b,c,d} through all 16 vectors, captures f1 into a truth table and
// compares it with EXP_TT. Define F1_SYNC_EN to pass f1 through a 2-flop synchronizer.
module f1_sweep_checker #(
    parameter int          DWELL_CYCLES = 50,
    parameter logic [15:0] EXP_TT       = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f1,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] tt,
    output logic [4:0]  err_cnt,
    output logic [3:0]  fail_idx
);

    typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

    localparam logic [15:0] LAST_CNT = 16'(DWELL_CYCLES - 1);

    state_t      state;
    logic [3:0]  idx;
    logic [15:0] cnt;
    logic        sample;

`ifdef F1_SYNC_EN
    logic f1_meta;
    logic f1_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f1_meta <= 1'b0;
            f1_sync <= 1'b0;
        end else begin
            f1_meta <= f1;
            f1_sync <= f1_meta;
        end
    end

    assign sample = f1_sync;
`else
    assign sample = f1;
`endif

    // The vector comes straight from the idx register, so it cannot glitch.
    assign {a, b, c, d} = idx;

    // Result of the sweep as it will look once the current sample is stored.
    logic [15:0] tt_final;
    logic [15:0] diff;
    logic [4:0]  diff_cnt;
    logic [3:0]  diff_idx;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        tt_final      = tt;
        tt_final[idx] = sample;
        diff          = tt_final ^ EXP_TT;
        diff_cnt      = 5'd0;
        diff_idx      = 4'd0;
        // Scanning downwards leaves the lowest mismatching index in diff_idx.
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) begin
                diff_cnt = diff_cnt + 5'd1;
                diff_idx = 4'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 4'd0;
            cnt      <= 16'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            tt       <= 16'd0;
            err_cnt  <= 5'd0;
            fail_idx <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= DRIVE;
                        idx      <= 4'd0;
                        cnt      <= 16'd0;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        tt       <= 16'd0;
                        err_cnt  <= 5'd0;
                        fail_idx <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= 16'd0;
                        tt  <= tt_final;
                        if (idx == 4'hF) begin
                            // Results are registered with done so they are valid together.
                            state    <= FINISH;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (diff == 16'd0);
                            err_cnt  <= diff_cnt;
                            fail_idx <= diff_idx;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
